// File: rtl/qfmt_pkg.sv
// Shared Q-format definitions: default word geometry, FSM state and operation encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package qfmt_pkg;

    localparam int Q_DEF = 15;
    localparam int N_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/qsub_bit.sv
// One-bit full adder / full subtractor cell for the bit-serial magnitude datapath.
// Latency: purely combinational.
// Backpressure: none; the caller registers cout between bits.
// Ports: x, y operand bits; cin carry (ADD) or borrow (SUB) in; op selects ADD/SUB;
//        r result bit; cout carry or borrow out.
module qsub_bit
    import qfmt_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  op_t  op,
    output logic r,
    output logic cout
);

    logic xy;

    assign xy = x ^ y;
    assign r  = xy ^ cin;

    always_comb begin
        cout = 1'b0;
        if (op == OP_ADD) begin
            cout = (x & y) | (cin & xy);
        end else begin
            // borrow out of x - y - cin
            cout = (~x & y) | (~xy & cin);
        end
    end

endmodule

// File: rtl/qsub_serial.sv
// Bit-serial sign-magnitude subtractor c = a - b, one magnitude bit per clock, LSB first.
// Latency: out_valid rises N-1 clocks after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-cycle re-accept.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with result c and overflow flag ovf.
module qsub_serial
    import qfmt_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int M  = N - 1;           // magnitude width
    localparam int CW = $clog2(N - 1);   // counter holds 0 .. N-2

    if (N < 3 || Q >= N) begin : g_param_check
        $error("qsub_serial: illegal parameters");
    end

    state_t        state_q, state_d;
    op_t           op_q;
    logic [M-1:0]  x_q, y_q, res_q;
    logic [CW-1:0] cnt_q;
    logic          cy_q;
    logic          rsign_q;
    logic [N-1:0]  c_q;
    logic          ovf_q;

    logic          accept;
    logic          last_bit;
    logic          bit_r, bit_cout;
    logic [M-1:0]  res_nxt;

    // operand decode at the accept edge: subtract is add of the negated b
    logic          sa, sb;
    logic [M-1:0]  ma, mb;
    logic          ma_gt_mb;

    assign sa       = a[N-1];
    assign sb       = ~b[N-1];
    assign ma       = a[M-1:0];
    assign mb       = b[M-1:0];
    assign ma_gt_mb = (ma > mb);

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == CW'(N - 2));
    assign res_nxt  = {bit_r, res_q[M-1:1]};

    qsub_bit u_bit (
        .x    (x_q[0]),
        .y    (y_q[0]),
        .cin  (cy_q),
        .op   (op_q),
        .r    (bit_r),
        .cout (bit_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            rsign_q <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            cy_q  <= 1'b0;
            cnt_q <= '0;
            if (sa == sb) begin
                op_q    <= OP_ADD;
                x_q     <= ma;
                y_q     <= mb;
                rsign_q <= sa;
            end else if (ma_gt_mb) begin
                op_q    <= OP_SUB;
                x_q     <= ma;
                y_q     <= mb;
                rsign_q <= sa;
            end else begin
                // larger (or equal) magnitude goes to x so the borrow never escapes
                op_q    <= OP_SUB;
                x_q     <= mb;
                y_q     <= ma;
                rsign_q <= sb;
            end
        end else if (state_q == SHIFT) begin
            x_q   <= x_q >> 1;
            y_q   <= y_q >> 1;
            res_q <= res_nxt;
            cy_q  <= bit_cout;
            cnt_q <= cnt_q + CW'(1);
            if (last_bit) begin
                // zero magnitude is forced positive, covering equal inputs and ADD wrap
                c_q   <= {rsign_q & (|res_nxt), res_nxt};
                ovf_q <= (op_q == OP_ADD) ? bit_cout : 1'b0;
            end
        end
    end

    assign c   = c_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_qsub_serial.sv
module tb_qsub_serial;

    localparam int N = 32;
    localparam int Q = 15;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    qsub_serial #(.Q(Q), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on the real values, then re-encode as sign-magnitude.
    task automatic model(input logic [N-1:0] aa, input logic [N-1:0] bb,
                         output logic [N-1:0] ec, output logic eo);
        longint va, vb, d, mag, lim;
        lim = longint'(1) << (N - 1);
        va  = longint'(aa[N-2:0]);
        vb  = longint'(bb[N-2:0]);
        if (aa[N-1]) va = -va;
        if (bb[N-1]) vb = -vb;
        d   = va - vb;
        mag = (d < 0) ? -d : d;
        eo  = (mag >= lim);
        mag = mag % lim;
        ec  = N'(mag);
        ec[N-1] = (d < 0) && (mag != 0);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] aa, input logic [N-1:0] bb,
                          input int hold);
        logic [N-1:0] ec;
        logic         eo;
        int           lat;
        model(aa, bb, ec, eo);
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(N - 1));
        check({tag, "_c"}, 64'(c), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        check({tag, "_c_hold"}, 64'(c), 64'(ec));
    endtask

    initial begin
        logic [N-1:0] ra, rb, ec, eo_c;
        logic         eo;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c", 64'(c), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed cases
        run_op("p3_m_p1", 32'h0001_8000, 32'h0000_8000, 0);
        check("p3_m_p1_const", 64'(c), 64'h0001_0000);
        run_op("p1_m_p3", 32'h0000_8000, 32'h0001_8000, 2);
        check("p1_m_p3_const", 64'(c), 64'h8001_0000);
        run_op("n1_m_n1", 32'h8000_8000, 32'h8000_8000, 0);
        check("n1_m_n1_const", 64'(c), 64'h0000_0000);
        run_op("p1_m_n2", 32'h0000_8000, 32'h8001_0000, 1);
        check("p1_m_n2_const", 64'(c), 64'h0001_8000);
        run_op("wrap", 32'h7FFF_FFFF, 32'h8000_0001, 0);
        check("wrap_c_const", 64'(c), 64'h0000_0000);
        check("wrap_ovf_const", 64'(ovf), 64'd1);

        // back-pressure: hold result 10 cycles with in_valid pulses that must be ignored
        model(32'h8002_0000, 32'h0000_4000, ec, eo);
        a        = 32'h8002_0000;
        b        = 32'h0000_4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_c", 64'(c), 64'(ec));
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_c", 64'(c), 64'(ec));

        // asynchronous reset in the middle of a shift
        a        = 32'h0003_0000;
        b        = 32'h8000_1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_c", 64'(c), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst", 32'h0003_0000, 32'h8000_1234, 0);

        // randomized operands, with forced equal magnitudes and extreme values mixed in
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 1) rb[N-2:0] = ra[N-2:0];
            if (k % 7 == 3) begin
                ra[N-2:0] = '1;
                rb[N-2:0] = N'($urandom_range(0, 3));
            end
            eo_c = ra;
            run_op("rand", eo_c, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
